// File: rtl/e_expand_salted_pipe_pkg.sv
// Shared constants and types for the salted DES E-expansion pipeline.
package e_expand_salted_pipe_pkg;

  localparam int SALT_MSB = 11;
  localparam int E_WIDTH  = 48;
  localparam int R_WIDTH  = 32;
  localparam int E_HALF   = E_WIDTH / 2;

  // RUN: shadow buffer free. PEND: shadow holds a salt waiting for the batch to end.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } salt_state_e;

  // Mask that keeps only the low 'bits' salt bits.
  function automatic logic [SALT_MSB:0] salt_mask(input int bits);
    logic [SALT_MSB:0] m;
    m = '0;
    for (int k = 0; k <= SALT_MSB; k++) begin
      if (k < bits) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/e_expand_salted.sv
// Combinational DES E-expansion of one 32-bit R half with salt-controlled bit swap.
module e_expand_salted
  import e_expand_salted_pipe_pkg::*;
(
  input  logic [R_WIDTH-1:0] i_r,
  input  logic [SALT_MSB:0]  i_salt,
  output logic [E_WIDTH-1:0] o_e
);

  logic [E_WIDTH-1:0] w_e0;

  // Standard E table: eight 6-bit groups, each overlapping its neighbours by one bit.
  assign w_e0 = {i_r[0], i_r[31:27], i_r[28:23], i_r[24:19], i_r[20:15],
                 i_r[16:11], i_r[12:7], i_r[8:3], i_r[4:0], i_r[31]};

  // Salt bit k exchanges expansion bits k and k+24.
  always_comb begin
    // NOTE: full default before the conditional overrides, so no latch is inferred.
    o_e = w_e0;
    for (int k = 0; k <= SALT_MSB; k++) begin
      if (i_salt[k]) begin
        o_e[k]          = w_e0[k+E_HALF];
        o_e[k+E_HALF]   = w_e0[k];
      end
    end
  end

endmodule

// File: rtl/e_expand_salted_pipe.sv
// Multi-channel elastic pipeline of salted E-expansions with a double-buffered batch salt.
module e_expand_salted_pipe
  import e_expand_salted_pipe_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SALT_BITS   = 12,
  parameter int PIPE_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [SALT_MSB:0]       salt_in,
  input  logic                    salt_valid,
  output logic                    salt_ready,
  input  logic [N_CH*R_WIDTH-1:0] in_r,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_CH*E_WIDTH-1:0] out_e,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int                LAST      = PIPE_STAGES - 1;
  localparam int                EW        = N_CH * E_WIDTH;
  localparam logic [SALT_MSB:0] SALT_MASK = salt_mask(SALT_BITS);

  salt_state_e          r_state;
  logic [SALT_MSB:0]    r_active_salt;
  logic [SALT_MSB:0]    r_shadow_salt;
  logic                 r_batch_open;
  logic                 r_salt_ready;

  logic [LAST:0]        r_v;
  logic [LAST:0]        r_last;
  logic [EW-1:0]        r_e [PIPE_STAGES];
  logic [LAST:0]        w_load;

  logic                 w_accept;
  logic                 w_close;
  logic                 w_salt_fire;
  logic [SALT_MSB:0]    w_salt_masked;
  logic [SALT_MSB:0]    w_item_salt;
  logic [EW-1:0]        w_e_in;

  assign w_salt_masked = salt_in & SALT_MASK;
  assign w_accept      = in_valid & in_ready;
  assign w_close       = w_accept & in_last;
  assign w_salt_fire   = salt_valid & r_salt_ready;

  // In PEND with no batch open the previous batch has just ended: new items take the shadow salt.
  assign w_item_salt = (r_state == ST_PEND && !r_batch_open) ? r_shadow_salt : r_active_salt;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    e_expand_salted u_exp (
      .i_r   (in_r[c*R_WIDTH +: R_WIDTH]),
      .i_salt(w_item_salt),
      .o_e   (w_e_in[c*E_WIDTH +: E_WIDTH])
    );
  end

  // A stage may load when it or any later stage has a hole, or the output is being taken.
  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_load
    assign w_load[i] = out_ready | ~(&r_v[LAST:i]);
  end

  // Salt FSM: stage into shadow, promote to active at the batch boundary.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= ST_RUN;
      r_active_salt <= '0;
      r_shadow_salt <= '0;
      r_batch_open  <= 1'b0;
      r_salt_ready  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below sees pre-edge state.
      if (w_accept) r_batch_open <= !in_last;
      case (r_state)
        ST_RUN: begin
          if (w_salt_fire) begin
            r_shadow_salt <= w_salt_masked;
            if (!r_batch_open) begin
              r_active_salt <= w_salt_masked;
            end else begin
              r_state      <= ST_PEND;
              r_salt_ready <= 1'b0;
            end
          end
        end
        ST_PEND: begin
          if (!r_batch_open || w_close) begin
            r_active_salt <= r_shadow_salt;
            r_state       <= ST_RUN;
            r_salt_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_salt_ready <= 1'b1;
        end
      endcase
    end
  end

  // Elastic stage registers: each stage takes its predecessor's content when allowed to load.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_v    <= '0;
      r_last <= '0;
      // NOTE: the data array is reset (unlike a RAM) because out_e must read 0 after reset.
      for (int i = 0; i < PIPE_STAGES; i++) r_e[i] <= '0;
    end else begin
      if (w_load[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_e[0]    <= w_e_in;
          r_last[0] <= in_last;
        end
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (w_load[i]) begin
          r_v[i] <= r_v[i-1];
          if (r_v[i-1]) begin
            r_e[i]    <= r_e[i-1];
            r_last[i] <= r_last[i-1];
          end
        end
      end
    end
  end

  assign salt_ready = r_salt_ready;
  assign in_ready   = w_load[0];
  assign out_valid  = r_v[LAST];
  assign out_last   = r_last[LAST];
  assign out_e      = r_e[LAST];

endmodule

// File: tb/tb_e_expand_salted_pipe.sv
// Randomised self-checking bench for e_expand_salted_pipe with a table-driven DES E reference.
module tb_e_expand_salted_pipe;

  localparam int N_CH    = 4;
  localparam int N_ITEMS = 10000;

  // DES E selection table, DES bit numbering (1 = MSB of R).
  localparam int E_TAB [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                                8, 9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,
                               24,25,26,27,28,29,28,29,30,31,32, 1};

  logic         clk;
  logic         rst_n;
  logic [11:0]  salt_in;
  logic         salt_valid;
  logic         salt_ready;
  logic [127:0] in_r;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] out_e;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  logic [11:0]  salt_in2;
  logic         salt_valid2;
  logic         salt_ready2;
  logic [31:0]  in_r2;
  logic         in_last2;
  logic         in_valid2;
  logic         in_ready2;
  logic [47:0]  out_e2;
  logic         out_last2;
  logic         out_valid2;
  logic         out_ready2;

  int n_checks = 0;
  int n_fail   = 0;

  e_expand_salted_pipe #(.N_CH(N_CH), .SALT_BITS(12), .PIPE_STAGES(2)) u_dut (
    .CLK(clk), .RST_N(rst_n),
    .salt_in(salt_in), .salt_valid(salt_valid), .salt_ready(salt_ready),
    .in_r(in_r), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_e(out_e), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  e_expand_salted_pipe #(.N_CH(1), .SALT_BITS(6), .PIPE_STAGES(1)) u_dut6 (
    .CLK(clk), .RST_N(rst_n),
    .salt_in(salt_in2), .salt_valid(salt_valid2), .salt_ready(salt_ready2),
    .in_r(in_r2), .in_last(in_last2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_e(out_e2), .out_last(out_last2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: select bits by the DES table, then swap bit pairs selected by the salt.
  function automatic logic [47:0] ref_e(input logic [31:0] r, input logic [11:0] s);
    logic [47:0] e;
    logic        t;
    for (int j = 0; j < 48; j++) e[47-j] = r[32-E_TAB[j]];
    for (int k = 0; k < 12; k++) begin
      if (s[k]) begin
        t       = e[k];
        e[k]    = e[k+24];
        e[k+24] = t;
      end
    end
    return e;
  endfunction

  function automatic logic [191:0] expand_all(input logic [127:0] r, input logic [11:0] s);
    logic [191:0] e;
    for (int c = 0; c < N_CH; c++) e[c*48 +: 48] = ref_e(r[c*32 +: 32], s);
    return e;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard / salt model (sampled on the falling edge) ----------------
  logic [192:0] exp_q [$];
  logic [191:0] last_out_e;
  logic [11:0]  m_cur, m_shadow, m_nxt;
  logic         m_pend, m_hold, m_open, m_nhold, m_item, m_salt;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cur = '0; m_shadow = '0; m_pend = 1'b0; m_hold = 1'b0; m_open = 1'b0;
    end else begin
      n_checks++;
      if (salt_ready !== !(m_pend || m_hold)) begin
        n_fail++;
        $display("FAIL salt_ready t=%0t got=%b want=%b", $time, salt_ready, !(m_pend || m_hold));
      end
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output t=%0t got=%h", $time, out_e);
        end else begin
          if ({out_last, out_e} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL output t=%0t got=%b/%h want=%b/%h", $time, out_last, out_e,
                     exp_q[0][192], exp_q[0][191:0]);
          end
          if (out_ready) begin
            last_out_e = out_e;
            void'(exp_q.pop_front());
          end
        end
      end
      m_item  = in_valid & in_ready;
      m_salt  = salt_valid & salt_ready;
      m_nxt   = m_cur;
      m_nhold = 1'b0;
      if (m_item) exp_q.push_back({in_last, expand_all(in_r, m_cur)});
      if (m_salt) begin
        if (!m_open) m_nxt = salt_in;
        else if (m_item && in_last) begin
          m_nxt   = salt_in;
          m_nhold = 1'b1;
        end else begin
          m_pend   = 1'b1;
          m_shadow = salt_in;
        end
      end
      if (m_pend && m_item && in_last) begin
        m_nxt  = m_shadow;
        m_pend = 1'b0;
      end
      if (m_item) m_open = !in_last;
      m_cur  = m_nxt;
      m_hold = m_nhold;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_item(input logic [127:0] r, input logic last);
    logic ok;
    @(posedge clk); #1;
    in_r = r; in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout t=%0t", $time);
    end
  endtask

  task automatic drive_salt(input logic [11:0] s);
    logic ok;
    @(posedge clk); #1;
    salt_in = s; salt_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (salt_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    salt_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL salt_timeout t=%0t", $time);
    end
  endtask

  task automatic drain();
    logic ok;
    @(posedge clk); #1;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain pending=%0d out_valid=%b", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks += 6;
    if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_e !== '0)        begin n_fail++; $display("FAIL reset_out_e got=%h want=0", out_e); end
    if (out_last !== 1'b0)   begin n_fail++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (salt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_salt_ready got=%b want=1", salt_ready); end
    if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid2 got=%b want=0", out_valid2); end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    send_item(128'h1, 1'b1);
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    n_checks += 3;
    if (lat != 2) begin n_fail++; $display("FAIL latency got=%0d want=2", lat); end
    if (out_e[47:0] !== ref_e(32'h1, 12'h0)) begin
      n_fail++; $display("FAIL basic_e got=%h want=%h", out_e[47:0], ref_e(32'h1, 12'h0));
    end
    if (out_last !== 1'b1) begin n_fail++; $display("FAIL basic_last got=%b want=1", out_last); end
    drain();
  endtask

  task automatic test_salt_idle();
    drive_salt(12'h001);
    send_item({96'h0, 32'h8000_0000}, 1'b1);
    drain();
    n_checks++;
    if (last_out_e[47:0] !== 48'h4000_0100_0000) begin
      n_fail++; $display("FAIL salt_idle got=%h want=400001000000", last_out_e[47:0]);
    end
  endtask

  task automatic test_batch();
    logic [127:0] r4;
    drive_salt(12'h000);
    send_item(rand128(), 1'b0);
    send_item(rand128(), 1'b0);
    drive_salt(12'hFFF);
    @(negedge clk);
    n_checks++;
    if (salt_ready !== 1'b0) begin n_fail++; $display("FAIL batch_pend_ready got=%b want=0", salt_ready); end
    send_item(rand128(), 1'b1);
    @(negedge clk);
    n_checks++;
    if (salt_ready !== 1'b1) begin n_fail++; $display("FAIL batch_run_ready got=%b want=1", salt_ready); end
    r4 = rand128();
    send_item(r4, 1'b1);
    drain();
    n_checks++;
    if (last_out_e !== expand_all(r4, 12'hFFF)) begin
      n_fail++; $display("FAIL batch_item4 got=%h want=%h", last_out_e, expand_all(r4, 12'hFFF));
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_r = rand128(); in_last = (i == 7); in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready i=%0d got=%b want=1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [191:0] snap;
    logic         have, acc, ok;
    int           n_acc;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_r = rand128(); in_last = 1'b1; in_valid = 1'b1;
    have = 1'b0; n_acc = 0; snap = '0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin snap = out_e; have = 1'b1; end
        else begin
          n_checks++;
          if (out_e !== snap) begin n_fail++; $display("FAIL stall_stable got=%h want=%h", out_e, snap); end
        end
      end
      acc = in_ready;
      if (acc) n_acc++;
      @(posedge clk); #1;
      if (acc) begin in_r = rand128(); in_last = $urandom_range(0, 1) == 1; end
    end
    @(negedge clk);
    n_checks += 2;
    if (n_acc != 2) begin n_fail++; $display("FAIL stall_accepts got=%0d want=2", n_acc); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b1;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL stall_release_timeout"); end
    send_item(rand128(), 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    logic [127:0] rz;
    out_ready = 1'b0;
    send_item(rand128(), 1'b0);
    drive_salt(12'hABC);
    send_item(rand128(), 1'b0);
    @(negedge clk);
    n_checks++;
    if (salt_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pend got=%b want=0", salt_ready); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    if (salt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_salt_ready got=%b want=1", salt_ready); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    rz = rand128();
    send_item(rz, 1'b1);
    drain();
    n_checks++;
    if (last_out_e !== expand_all(rz, 12'h000)) begin
      n_fail++; $display("FAIL mid_salt0 got=%h want=%h", last_out_e, expand_all(rz, 12'h000));
    end
  endtask

  task automatic test_random();
    int   n_sent, cyc;
    logic acc, sacc;
    n_sent = 0; cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; salt_valid = 1'b0;
    while (n_sent < N_ITEMS && cyc < 60000) begin
      @(negedge clk);
      acc  = in_valid & in_ready;
      sacc = salt_valid & salt_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) n_sent++;
      if (acc || !in_valid) begin
        if (n_sent < N_ITEMS && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1; in_r = rand128(); in_last = $urandom_range(0, 3) == 0;
        end else in_valid = 1'b0;
      end
      if (sacc || !salt_valid) begin
        salt_valid = $urandom_range(0, 15) == 0;
        salt_in    = 12'($urandom);
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    in_valid = 1'b0; salt_valid = 1'b0;
    n_checks++;
    if (n_sent != N_ITEMS) begin n_fail++; $display("FAIL random_sent got=%0d want=%0d", n_sent, N_ITEMS); end
    send_item(rand128(), 1'b1);
    drain();
  endtask

  task automatic test_mask();
    logic [11:0] s;
    logic [31:0] r;
    logic        ok;
    for (int i = 0; i < 12; i++) begin
      s = (i == 0) ? 12'hFC0 : 12'($urandom);
      @(posedge clk); #1;
      salt_in2 = s; salt_valid2 = 1'b1;
      @(negedge clk);
      n_checks++;
      if (salt_ready2 !== 1'b1) begin n_fail++; $display("FAIL mask_salt_ready i=%0d got=%b", i, salt_ready2); end
      @(posedge clk); #1;
      salt_valid2 = 1'b0;
      r = $urandom;
      in_r2 = r; in_last2 = 1'b1; in_valid2 = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL mask_in_ready i=%0d got=%b", i, in_ready2); end
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 5; t++) begin
        @(negedge clk);
        if (out_valid2) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL mask_timeout i=%0d", i);
      end else if ({out_last2, out_e2} !== {1'b1, ref_e(r, s & 12'h03F)}) begin
        n_fail++;
        $display("FAIL mask_out i=%0d salt=%h got=%b/%h want=1/%h", i, s, out_last2, out_e2, ref_e(r, s & 12'h03F));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    salt_in = '0; salt_valid = 1'b0; in_r = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    salt_in2 = '0; salt_valid2 = 1'b0; in_r2 = '0; in_last2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    last_out_e = '0;
    test_reset();
    test_basic();
    test_salt_idle();
    test_batch();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_mask();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
